// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the next-address sequencer in front of program_counter.
package pc_sequencer_pkg;

  localparam int ADDR_W = 32;

  localparam logic [ADDR_W-1:0] VEC_ADDR = 32'd60;
  localparam logic [ADDR_W-1:0] START0   = 32'hFFFF_FFFF;
  localparam logic [ADDR_W-1:0] START1   = 32'd14;
  localparam logic [ADDR_W-1:0] START2   = 32'd29;

  localparam logic [1:0] PROGR_0    = 2'b00;
  localparam logic [1:0] PROGR_1    = 2'b01;
  localparam logic [1:0] PROGR_RSVD = 2'b10;
  localparam logic [1:0] PROGR_2    = 2'b11;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_ISR  = 2'd2
  } state_e;

endpackage

// File: rtl/pc_sequencer_if.sv
// Control bus between the pipeline (master) and the next-address sequencer (slave).
interface pc_sequencer_if;
  import pc_sequencer_pkg::*;

  // Single-cycle control bus: no valid/ready handshake; every input is sampled on
  // every rising clock edge and next_address is valid combinationally each cycle.
  logic [1:0]        progr;
  logic [ADDR_W-1:0] pc_current;
  logic              stall;
  logic              branch_taken;
  logic [ADDR_W-1:0] branch_target;
  logic              jump;
  logic [ADDR_W-1:0] jump_target;
  logic              interrupt;
  logic              eret;
  logic [ADDR_W-1:0] next_address;
  logic [ADDR_W-1:0] epc;
  logic              in_isr;
  logic              int_ack;

  modport master (
    output progr, pc_current, stall, branch_taken, branch_target,
           jump, jump_target, interrupt, eret,
    input  next_address, epc, in_isr, int_ack
  );

  modport slave (
    input  progr, pc_current, stall, branch_taken, branch_target,
           jump, jump_target, interrupt, eret,
    output next_address, epc, in_isr, int_ack
  );

endinterface

// File: rtl/pc_sequencer_int_latch.sv
// Interrupt rising-edge detector with a sticky pending flag; edges while pending merge.
module pc_sequencer_int_latch (
  input  logic clock,
  input  logic reset,
  input  logic interrupt_i,
  input  logic clear_i,
  output logic pending_o
);

  logic prev_q;
  logic pending_q;
  logic pending_d;
  logic rise;

  assign rise = interrupt_i & ~prev_q;

  // A fresh edge in the same cycle as a clear is a new event and survives it.
  assign pending_d = rise | (pending_q & ~clear_i);

  always_ff @(posedge clock) begin
    if (!reset) begin
      prev_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      prev_q    <= interrupt_i;
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/pc_sequencer.sv
// Selects the address program_counter loads each cycle: boot, sequential, jump, branch, vector or eret.
module pc_sequencer
  import pc_sequencer_pkg::*;
(
  input  logic         clock,
  input  logic         reset,
  pc_sequencer_if.slave bus,
  output state_e       dbg_state_o
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic              in_isr_q, in_isr_d;
  logic              int_ack_q, int_ack_d;
  logic              take_int;
  logic              pending;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] start_addr;

  assign pc_inc = bus.pc_current + {{(ADDR_W-1){1'b0}}, 1'b1};

  always_comb begin
    start_addr = START0;
    case (bus.progr)
      PROGR_1: start_addr = START1;
      PROGR_2: start_addr = START2;
      default: start_addr = START0;
    endcase
  end

  pc_sequencer_int_latch u_int_latch (
    .clock       (clock),
    .reset       (reset),
    .interrupt_i (bus.interrupt),
    .clear_i     (take_int),
    .pending_o   (pending)
  );

  always_comb begin
    state_d   = state_q;
    epc_d     = epc_q;
    in_isr_d  = in_isr_q;
    take_int  = 1'b0;
    next_addr = pc_inc;
    if (!reset) begin
      next_addr = start_addr;
    end else begin
      case (state_q)
        ST_BOOT: begin
          next_addr = pc_inc;
          state_d   = ST_RUN;
        end
        ST_RUN: begin
          // Control transfers outrank the interrupt so epc never skips a taken jump/branch.
          if (bus.stall) begin
            next_addr = bus.pc_current;
          end else if (bus.jump) begin
            next_addr = bus.jump_target;
          end else if (bus.branch_taken) begin
            next_addr = bus.branch_target;
          end else if (pending) begin
            next_addr = VEC_ADDR;
            epc_d     = pc_inc;
            in_isr_d  = 1'b1;
            take_int  = 1'b1;
            state_d   = ST_ISR;
          end
        end
        ST_ISR: begin
          if (bus.stall) begin
            next_addr = bus.pc_current;
          end else if (bus.eret) begin
            next_addr = epc_q;
            in_isr_d  = 1'b0;
            state_d   = ST_RUN;
          end else if (bus.jump) begin
            next_addr = bus.jump_target;
          end else if (bus.branch_taken) begin
            next_addr = bus.branch_target;
          end
        end
        default: state_d = ST_BOOT;
      endcase
    end
  end

  assign int_ack_d = take_int;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_BOOT;
      epc_q     <= '0;
      in_isr_q  <= 1'b0;
      int_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      epc_q     <= epc_d;
      in_isr_q  <= in_isr_d;
      int_ack_q <= int_ack_d;
    end
  end

  assign bus.next_address = next_addr;
  assign bus.epc          = epc_q;
  assign bus.in_isr       = in_isr_q;
  assign bus.int_ack      = int_ack_q;
  assign dbg_state_o      = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: pc_current is driven by hand, expectations are hand-computed.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  logic   clock = 1'b0;
  logic   reset;
  state_e dbg_state;
  int     tests  = 0;
  int     failed = 0;

  pc_sequencer_if bus ();

  pc_sequencer dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    bus.stall         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = '0;
    bus.jump          = 1'b0;
    bus.jump_target   = '0;
    bus.eret          = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; bus.progr = 2'b01; bus.interrupt = 1'b0; bus.pc_current = '0;
    idle();
    tick(); tick();
    tests++; if (bus.next_address !== 32'd14) begin failed++; $display("FAIL rst_next_p01: got %h want %h", bus.next_address, 32'd14); end
    tests++; if (bus.epc !== 32'd0) begin failed++; $display("FAIL rst_epc: got %h want %h", bus.epc, 32'd0); end
    tests++; if (bus.in_isr !== 1'b0 || bus.int_ack !== 1'b0) begin failed++; $display("FAIL rst_flags: got isr=%b ack=%b want 0 0", bus.in_isr, bus.int_ack); end
    tests++; if (dbg_state !== ST_BOOT) begin failed++; $display("FAIL rst_state: got %0d want %0d", dbg_state, ST_BOOT); end
    reset = 1'b1; bus.pc_current = 32'd14;
    #1;
    tests++; if (bus.next_address !== 32'd15) begin failed++; $display("FAIL boot_next: got %h want %h", bus.next_address, 32'd15); end
    tick(); bus.pc_current = 32'd15;
    #1;
    tests++; if (bus.next_address !== 32'd16 || dbg_state !== ST_RUN) begin failed++; $display("FAIL run_first: got %h st=%0d want %h st=%0d", bus.next_address, dbg_state, 32'd16, ST_RUN); end
    // Other boot programs, including the reserved encoding.
    reset = 1'b0; bus.progr = 2'b11;
    tick();
    tests++; if (bus.next_address !== 32'd29) begin failed++; $display("FAIL rst_next_p11: got %h want %h", bus.next_address, 32'd29); end
    bus.progr = 2'b10;
    #1;
    tests++; if (bus.next_address !== 32'hFFFF_FFFF) begin failed++; $display("FAIL rst_next_p10: got %h want %h", bus.next_address, 32'hFFFF_FFFF); end
    bus.progr = 2'b00;
    #1;
    tests++; if (bus.next_address !== 32'hFFFF_FFFF) begin failed++; $display("FAIL rst_next_p00: got %h want %h", bus.next_address, 32'hFFFF_FFFF); end
    tick();
    reset = 1'b1; bus.pc_current = 32'hFFFF_FFFF;
    #1;
    tests++; if (bus.next_address !== 32'd0) begin failed++; $display("FAIL boot_wrap: got %h want %h", bus.next_address, 32'd0); end
    tick(); bus.pc_current = 32'd0;
    #1;
    tests++; if (bus.next_address !== 32'd1) begin failed++; $display("FAIL run_after_wrap: got %h want %h", bus.next_address, 32'd1); end
  endtask

  task automatic test_interrupt();
    bus.pc_current = 32'd20; bus.interrupt = 1'b1;
    #1;
    tests++; if (bus.next_address !== 32'd21) begin failed++; $display("FAIL int_same_cycle: got %h want %h", bus.next_address, 32'd21); end
    tick();
    tests++; if (bus.next_address !== 32'd60) begin failed++; $display("FAIL int_vector: got %h want %h", bus.next_address, 32'd60); end
    tests++; if (bus.in_isr !== 1'b0 || bus.int_ack !== 1'b0) begin failed++; $display("FAIL int_pre_flags: got isr=%b ack=%b want 0 0", bus.in_isr, bus.int_ack); end
    tick();
    bus.pc_current = 32'd60; bus.interrupt = 1'b0;
    tests++; if (bus.epc !== 32'd21) begin failed++; $display("FAIL int_epc: got %h want %h", bus.epc, 32'd21); end
    tests++; if (bus.in_isr !== 1'b1 || bus.int_ack !== 1'b1 || dbg_state !== ST_ISR) begin failed++; $display("FAIL int_enter: got isr=%b ack=%b st=%0d want 1 1 %0d", bus.in_isr, bus.int_ack, dbg_state, ST_ISR); end
    #1;
    tests++; if (bus.next_address !== 32'd61) begin failed++; $display("FAIL isr_seq: got %h want %h", bus.next_address, 32'd61); end
    tick();
    tests++; if (bus.int_ack !== 1'b0 || bus.in_isr !== 1'b1) begin failed++; $display("FAIL int_ack_pulse: got ack=%b isr=%b want 0 1", bus.int_ack, bus.in_isr); end
  endtask

  task automatic test_eret();
    bus.pc_current = 32'd61; bus.interrupt = 1'b1;
    #1;
    tests++; if (bus.next_address !== 32'd62) begin failed++; $display("FAIL isr_no_nest: got %h want %h", bus.next_address, 32'd62); end
    tick();
    bus.pc_current = 32'd62; bus.eret = 1'b1;
    #1;
    tests++; if (bus.next_address !== 32'd21) begin failed++; $display("FAIL eret_next: got %h want %h", bus.next_address, 32'd21); end
    tick();
    bus.eret = 1'b0; bus.pc_current = 32'd21; bus.interrupt = 1'b0;
    tests++; if (bus.in_isr !== 1'b0 || dbg_state !== ST_RUN) begin failed++; $display("FAIL eret_exit: got isr=%b st=%0d want 0 %0d", bus.in_isr, dbg_state, ST_RUN); end
    #1;
    tests++; if (bus.next_address !== 32'd60) begin failed++; $display("FAIL eret_revector: got %h want %h", bus.next_address, 32'd60); end
    tick();
    tests++; if (bus.epc !== 32'd22 || bus.int_ack !== 1'b1) begin failed++; $display("FAIL revector_epc: got %h ack=%b want %h 1", bus.epc, bus.int_ack, 32'd22); end
    bus.pc_current = 32'd60; bus.eret = 1'b1;
    tick();
    bus.eret = 1'b0;
  endtask

  task automatic test_jump_defer();
    bus.pc_current = 32'd28; bus.interrupt = 1'b1;
    #1;
    tests++; if (bus.next_address !== 32'd29) begin failed++; $display("FAIL jd_pre: got %h want %h", bus.next_address, 32'd29); end
    tick();
    bus.pc_current = 32'd30; bus.jump = 1'b1; bus.jump_target = 32'd100;
    #1;
    tests++; if (bus.next_address !== 32'd100) begin failed++; $display("FAIL jd_jump_first: got %h want %h", bus.next_address, 32'd100); end
    tick();
    idle(); bus.pc_current = 32'd100; bus.interrupt = 1'b0;
    tests++; if (bus.in_isr !== 1'b0) begin failed++; $display("FAIL jd_not_taken: got isr=%b want 0", bus.in_isr); end
    #1;
    tests++; if (bus.next_address !== 32'd60) begin failed++; $display("FAIL jd_vector: got %h want %h", bus.next_address, 32'd60); end
    tick();
    tests++; if (bus.epc !== 32'd101) begin failed++; $display("FAIL jd_epc: got %h want %h", bus.epc, 32'd101); end
    bus.pc_current = 32'd60; bus.eret = 1'b1;
    #1;
    tests++; if (bus.next_address !== 32'd101) begin failed++; $display("FAIL jd_eret: got %h want %h", bus.next_address, 32'd101); end
    tick();
    idle();
  endtask

  task automatic test_stall();
    bus.pc_current = 32'd40; bus.stall = 1'b1; bus.interrupt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (bus.next_address !== 32'd40 || bus.in_isr !== 1'b0) begin failed++; $display("FAIL stall_hold%0d: got %h isr=%b want %h 0", i, bus.next_address, bus.in_isr, 32'd40); end
      tick();
      bus.interrupt = 1'b0;
    end
    bus.stall = 1'b0;
    #1;
    tests++; if (bus.next_address !== 32'd60) begin failed++; $display("FAIL stall_release: got %h want %h", bus.next_address, 32'd60); end
    tick();
    tests++; if (bus.epc !== 32'd41 || bus.int_ack !== 1'b1) begin failed++; $display("FAIL stall_epc: got %h ack=%b want %h 1", bus.epc, bus.int_ack, 32'd41); end
    bus.pc_current = 32'd60; bus.stall = 1'b1; bus.eret = 1'b1;
    #1;
    tests++; if (bus.next_address !== 32'd60) begin failed++; $display("FAIL stall_eret_hold: got %h want %h", bus.next_address, 32'd60); end
    tick();
    tests++; if (dbg_state !== ST_ISR) begin failed++; $display("FAIL stall_eret_state: got %0d want %0d", dbg_state, ST_ISR); end
    bus.stall = 1'b0; bus.jump = 1'b1; bus.jump_target = 32'd200;
    #1;
    tests++; if (bus.next_address !== 32'd41) begin failed++; $display("FAIL eret_over_jump: got %h want %h", bus.next_address, 32'd41); end
    tick();
    idle();
  endtask

  task automatic test_run_corners();
    bus.pc_current = 32'd5; bus.eret = 1'b1;
    #1;
    tests++; if (bus.next_address !== 32'd6) begin failed++; $display("FAIL eret_in_run: got %h want %h", bus.next_address, 32'd6); end
    tick();
    bus.eret = 1'b0;
    tests++; if (bus.epc !== 32'd41 || bus.in_isr !== 1'b0) begin failed++; $display("FAIL eret_run_epc: got %h isr=%b want %h 0", bus.epc, bus.in_isr, 32'd41); end
    bus.pc_current = 32'hFFFF_FFFF;
    #1;
    tests++; if (bus.next_address !== 32'd0) begin failed++; $display("FAIL run_wrap: got %h want %h", bus.next_address, 32'd0); end
    bus.pc_current = 32'd7; bus.branch_taken = 1'b1; bus.branch_target = 32'h0000_1234;
    #1;
    tests++; if (bus.next_address !== 32'h0000_1234) begin failed++; $display("FAIL branch: got %h want %h", bus.next_address, 32'h0000_1234); end
    bus.jump = 1'b1; bus.jump_target = 32'h0000_0ABC;
    #1;
    tests++; if (bus.next_address !== 32'h0000_0ABC) begin failed++; $display("FAIL jump_over_branch: got %h want %h", bus.next_address, 32'h0000_0ABC); end
    tick();
    idle();
  endtask

  task automatic test_reset_mid_isr();
    bus.pc_current = 32'd70; bus.interrupt = 1'b1;
    tick();
    tick();
    bus.pc_current = 32'd60; bus.interrupt = 1'b0;
    tick();
    bus.pc_current = 32'd61; bus.interrupt = 1'b1;
    tick();
    reset = 1'b0; bus.interrupt = 1'b0; bus.progr = 2'b01;
    tick();
    tests++; if (bus.in_isr !== 1'b0 || bus.epc !== 32'd0 || bus.int_ack !== 1'b0) begin failed++; $display("FAIL mid_isr_reset: got isr=%b epc=%h ack=%b want 0 0 0", bus.in_isr, bus.epc, bus.int_ack); end
    tests++; if (bus.next_address !== 32'd14) begin failed++; $display("FAIL mid_isr_start: got %h want %h", bus.next_address, 32'd14); end
    reset = 1'b1; bus.pc_current = 32'd14;
    #1;
    tests++; if (bus.next_address !== 32'd15) begin failed++; $display("FAIL mid_isr_boot: got %h want %h", bus.next_address, 32'd15); end
    tick();
    bus.pc_current = 32'd15;
    #1;
    tests++; if (bus.next_address !== 32'd16) begin failed++; $display("FAIL mid_isr_no_vec1: got %h want %h", bus.next_address, 32'd16); end
    tick();
    bus.pc_current = 32'd16;
    #1;
    tests++; if (bus.next_address !== 32'd17 || bus.in_isr !== 1'b0) begin failed++; $display("FAIL mid_isr_no_vec2: got %h isr=%b want %h 0", bus.next_address, bus.in_isr, 32'd17); end
  endtask

  initial begin
    test_reset();
    test_interrupt();
    test_eret();
    test_jump_defer();
    test_stall();
    test_run_corners();
    test_reset_mid_isr();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
